alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: request handshake with operands, result handshake with status.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply and restoring divide.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   acc_r;

    logic             accept;
    logic             start_long;
    logic [WIDTH-1:0] short_res;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] x_n;
    logic [WIDTH-1:0] y_n;
    logic [WIDTH-1:0] long_res;

    function automatic logic [WIDTH-1:0] alu_short(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return sa >>> sh;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            // Only the divide-by-zero cases of DIVU/REMU ever resolve here
            OP_DIVU: return '1;
            OP_REMU: return a;
            default: return '0;
        endcase
    endfunction

    assign accept     = (state == IDLE) && bus.in_valid;
    assign start_long = (bus.op == OP_MUL) ||
                        (((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (bus.b != '0));
    assign short_res  = alu_short(bus.op, bus.a, bus.b);

    // One iteration: MUL adds shifted multiplicand; DIVU/REMU shift in a dividend bit and trial-subtract
    always_comb begin
        rem_sh = {acc_r[WIDTH-1:0], y_r[WIDTH-1]};
        diff   = rem_sh - {1'b0, x_r};
        acc_n  = acc_r;
        x_n    = x_r;
        y_n    = y_r;
        if (op_r == OP_MUL) begin
            acc_n = {1'b0, acc_r[WIDTH-1:0] + (y_r[0] ? x_r : '0)};
            x_n   = x_r << 1;
            y_n   = y_r >> 1;
        end else if (!diff[WIDTH]) begin
            acc_n = diff;
            y_n   = {y_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = rem_sh;
            y_n   = {y_r[WIDTH-2:0], 1'b0};
        end
        long_res = (op_r == OP_DIVU) ? y_n : acc_n[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    if (start_long) begin
                        state <= BUSY;
                    end else begin
                        state    <= DONE;
                        result_r <= short_res;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state    <= DONE;
                        result_r <= long_res;
                        cnt      <= '0;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/working registers carry no reset; they are always reloaded on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= bus.op;
            acc_r <= '0;
            if (bus.op == OP_MUL) begin
                x_r <= bus.a;
                y_r <= bus.b;
            end else begin
                x_r <= bus.b;
                y_r <= bus.a;
            end
        end else if (state == BUSY) begin
            acc_r <= acc_n;
            x_r   <= x_n;
            y_r   <= y_n;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_r;
    assign bus.zero      = (result_r == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned prod;
        int              sa;
        int              sb;
        int unsigned     sh;
        sh = b % 32;
        sa = a;
        sb = b;
        prod = longint'(a) * longint'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return prod[31:0];
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10 || ((op == 4'd11 || op == 4'd12) && b != 0)) return 33;
        return 1;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        bit flags_ok;
        bit hold_ok;
        chk("in_ready_pre", bus.in_ready, 1);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
        lat = 0;
        flags_ok = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (bus.in_ready || !bus.busy) flags_ok = 1'b0;
            bus.in_valid = 1'($urandom);
            bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
        end
        bus.in_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("busy_flags", flags_ok, 1);
        chk("result", bus.result, exp);
        chk("zero", bus.zero, exp == 0);
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.result !== exp || bus.zero !== (exp == 0))
                hold_ok = 1'b0;
            bus.in_valid = 1'($urandom);
            bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
        end
        bus.in_valid = 1'b0;
        if (hold > 0) chk("hold_stable", hold_ok, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after", {bus.out_valid, bus.in_ready}, 2'b01);
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic rnd_op();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        case ($urandom_range(0, 3))
            0: b = 32'h0;
            1: b = $urandom_range(1, 300);
            default: b = $urandom;
        endcase
        do_op(op, a, b, model(op, a, b), model_lat(op, b), $urandom_range(0, 3));
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);
        rst = 1'b0;

        do_op(4'd0,  32'hFFFF_FFFF, 32'd1,        32'h0,         1, 0);
        do_op(4'd7,  32'h8000_0000, 32'h24,       32'hF800_0000, 1, 0);
        do_op(4'd10, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 33, 0);
        do_op(4'd11, 32'd100,       32'd7,        32'd14,        33, 0);
        do_op(4'd12, 32'd100,       32'd7,        32'd2,         33, 0);
        do_op(4'd11, 32'd5,         32'd0,        32'hFFFF_FFFF, 1, 0);
        do_op(4'd12, 32'd5,         32'd0,        32'd5,         1, 0);
        do_op(4'd8,  32'hFFFF_FFFF, 32'd1,        32'd1,         1, 0);
        do_op(4'd9,  32'hFFFF_FFFF, 32'd1,        32'd0,         1, 0);
        do_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,        1, 0);
        do_op(4'd1,  32'd3,         32'd5,        32'hFFFF_FFFE, 1, 10);

        // Reset in the middle of a multiply discards it
        bus.op = 4'd10; bus.a = 32'h1234_5678; bus.b = 32'h0F0F_0F0F; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_result", bus.result, 0);
        chk("mrst_zero", bus.zero, 1);
        chk("mrst_in_ready", bus.in_ready, 1);
        do_op(4'd0, 32'd2, 32'd2, 32'd4, 1, 0);

        // Reset while holding a result under backpressure
        bus.op = 4'd4; bus.a = 32'hF0; bus.b = 32'h0F; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("drst_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("drst_out_valid", bus.out_valid, 0);
        chk("drst_result", bus.result, 0);

        for (int i = 0; i < 80; i++) rnd_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
